sopc_bus_fabric: RTL and testbench
==================================

Name: sopc_bus_fabric

Overview:
- Parametrised data-side interconnect for the SoPC top level; it replaces the direct core-to-data_ram wiring.
- Routes the core's single data-memory port to NUM_SLAVES memory-mapped slaves (data RAM, timer, UART, GPIO…).
- Address selection uses a fixed decode field.
- Adds a request/acknowledge handshake with variable slave latency, pipeline stall back to the core, bus-error signalling for unmapped or timed-out accesses, and per-slave read-data muxing.

Parameters:
NUM_SLAVES, 4, number of slave ports, legal range 1..8
DEC_HI, 31, MSB of address decode field
DEC_LO, 28, LSB of address decode field; field width DEC_HI-DEC_LO+1 must be at least clog2(NUM_SLAVES)
TIMEOUT, 15, maximum ACCESS cycles awaiting ack before error; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cpu_ce_i  in  1  core data request valid
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  32  byte address
cpu_sel_i  in  4  byte lane enables
cpu_data_i  in  32  write data from core
cpu_data_o  out  32  read data to core
cpu_stall_o  out  1  stall request to core pipeline
cpu_err_o  out  1  bus error pulse
s_ce_o  out  NUM_SLAVES  one-hot slave select
s_we_o  out  1  broadcast write enable
s_addr_o  out  32  broadcast address
s_sel_o  out  4  broadcast byte enables
s_data_o  out  32  broadcast write data
s_data_i  in  32*NUM_SLAVES  slave read data, slave k at bits [32k+31:32k]
s_ack_i  in  NUM_SLAVES  slave completion, one per slave

Behaviour:
Reset (async, immediate):
- State IDLE.
- s_ce_o=0, s_we_o=0, s_addr_o=0, s_sel_o=0, s_data_o=0.
- cpu_data_o=0, cpu_err_o=0, cpu_stall_o=0.
- Timeout counter=0.
- Reset mid-transaction abandons it; no ack or error is reported afterwards.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- cpu_stall_o = cpu_ce_i (combinational).
- On cpu_ce_i=1:
  - Register we/addr/sel/data onto the s_* broadcast outputs.
  - Compute idx = cpu_addr_i[DEC_HI:DEC_LO].
  - If idx < NUM_SLAVES: set s_ce_o[idx]=1 (registered), clear counter, go to ACCESS.
  - Else (unmapped): set err flag, go to DONE. No slave is selected.
- s_ack_i is ignored in IDLE.

ACCESS:
- cpu_stall_o=1.
- s_ce_o and the broadcast signals hold their registered values.
- The counter increments each cycle.
- If s_ack_i[idx]=1:
  - For a read, capture s_data_i[idx] into cpu_data_o.
  - Clear s_ce_o and go to DONE with err=0.
- Else if TIMEOUT≠0 and the counter reaches TIMEOUT-1:
  - Clear s_ce_o and go to DONE with err=1.
  - cpu_data_o is unchanged.
- Ack and timeout in the same cycle: ack wins.
- Acks from non-selected slaves are ignored.

DONE:
- cpu_stall_o=0.
- cpu_err_o = err flag, a one-cycle pulse.
- Next state is IDLE unconditionally; the held cpu_ce_i does not retrigger.
- The core advances its pipeline on this cycle.

Latency:
- Mapped access with ack in the first ACCESS cycle: stall high 2 cycles; data/err valid in cycle 2, counting the request cycle as 0.
- Each additional slave wait state adds 1 cycle.
- Unmapped access: stall 1 cycle, error in cycle 1.

Data rules:
- cpu_data_o holds its last captured read value until the next successful read.
- Writes do not alter cpu_data_o.
- Only s_sel_o qualifies byte lanes; the fabric does not shift or mask data.
- TIMEOUT counter width is clog2(TIMEOUT+1), minimum 1.
- NUM_SLAVES=1: decode still checks idx==0.

Test Plan:
- Read slave 1 at 0x1000_0010, slave acks first ACCESS cycle with 0xDEADBEEF → s_ce_o=4'b0010 for 1 cycle; stall high cycles 0–1; cpu_data_o=0xDEADBEEF and stall=0 in cycle 2; err=0.
- Write slave 0 at 0x0000_0004, sel=4'b0011, data 0x1234_5678, ack after 3 wait states → s_we_o=1, s_sel_o=4'b0011, s_data_o=0x12345678 held 4 ACCESS cycles; stall 5 cycles; cpu_data_o unchanged.
- Access 0x5000_0000 with NUM_SLAVES=4 → s_ce_o stays 0; stall 1 cycle; cpu_err_o=1 for exactly 1 cycle in cycle 1.
- Slave 2 never acks, TIMEOUT=15 → s_ce_o[2] high 15 cycles then drops; err pulse in the next cycle; state returns to IDLE; a following good access completes normally.
- Two cases: (a) ack arrives on the timeout cycle → completes with err=0 and data captured; (b) rst asserted in the middle of ACCESS → all outputs 0 immediately and stall 0, with no err pulse after release.
- Spurious s_ack_i[3] while slave 1 is selected, and s_ack_i pulse while IDLE → both ignored; the transaction waits for s_ack_i[1].

Source files
------------

// File: rtl/sopc_bus_fabric.sv
// Data-side interconnect: decodes the core's single data port onto NUM_SLAVES
// memory-mapped slaves with an ack handshake, pipeline stall and bus-error reporting.
module sopc_bus_fabric #(
   parameter int NUM_SLAVES = 4,
   parameter int DEC_HI     = 31,
   parameter int DEC_LO     = 28,
   parameter int TIMEOUT    = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_ce_i,
   input  logic                    cpu_we_i,
   input  logic [31:0]             cpu_addr_i,
   input  logic [3:0]              cpu_sel_i,
   input  logic [31:0]             cpu_data_i,
   output logic [31:0]             cpu_data_o,
   output logic                    cpu_stall_o,
   output logic                    cpu_err_o,
   output logic [NUM_SLAVES-1:0]   s_ce_o,
   output logic                    s_we_o,
   output logic [31:0]             s_addr_o,
   output logic [3:0]              s_sel_o,
   output logic [31:0]             s_data_o,
   input  logic [32*NUM_SLAVES-1:0] s_data_i,
   input  logic [NUM_SLAVES-1:0]   s_ack_i
);

   localparam int DEC_W = DEC_HI - DEC_LO + 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [DEC_W:0]   NUM_SLAVES_L = (DEC_W + 1)'(NUM_SLAVES);
   localparam logic [CNT_W-1:0] CNT_LAST_L   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam bit               TIMEOUT_EN_L = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [NUM_SLAVES-1:0] r_ce, w_ce_nxt;
   logic                  r_we, w_we_nxt;
   logic [31:0]           r_addr, w_addr_nxt;
   logic [3:0]            r_sel, w_sel_nxt;
   logic [31:0]           r_wdata, w_wdata_nxt;
   logic [31:0]           r_rdata, w_rdata_nxt;
   logic                  r_err, w_err_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  w_stall;

   logic [DEC_W-1:0]      w_idx;
   logic                  w_mapped;
   logic [NUM_SLAVES-1:0] w_onehot;
   logic                  w_ack_sel;
   logic [31:0]           w_rdata_mux;
   logic                  w_timeout;

   // Address decode, ack qualification and read-data mux keyed by the live slave select
   always_comb begin
      w_idx       = cpu_addr_i[DEC_HI:DEC_LO];
      w_mapped    = ({1'b0, w_idx} < NUM_SLAVES_L);
      w_ack_sel   = |(s_ack_i & r_ce);
      w_timeout   = TIMEOUT_EN_L && (r_cnt == CNT_LAST_L);
      w_onehot    = '0;
      w_rdata_mux = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         w_onehot[k] = (w_idx == DEC_W'(k));
         w_rdata_mux = w_rdata_mux | (s_data_i[32*k +: 32] & {32{r_ce[k]}});
      end
   end

   // Next-state logic, next register values and the stall request
   always_comb begin
      w_state_nxt = r_state;
      w_ce_nxt    = r_ce;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_sel_nxt   = r_sel;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stall = cpu_ce_i;
            if (cpu_ce_i) begin
               w_we_nxt    = cpu_we_i;
               w_addr_nxt  = cpu_addr_i;
               w_sel_nxt   = cpu_sel_i;
               w_wdata_nxt = cpu_data_i;
               w_cnt_nxt   = '0;
               if (w_mapped) begin
                  w_ce_nxt    = w_onehot;
                  w_state_nxt = ST_ACCESS;
               end else begin
                  w_ce_nxt    = '0;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_ce_nxt = '0;
            end
         end
         ST_ACCESS: begin
            w_stall = 1'b1;
            // An ack on the final timeout cycle still completes cleanly
            if (w_ack_sel) begin
               if (!r_we) begin
                  w_rdata_nxt = w_rdata_mux;
               end else begin
                  w_rdata_nxt = r_rdata;
               end
               w_ce_nxt    = '0;
               w_state_nxt = ST_DONE;
            end else if (w_timeout) begin
               w_ce_nxt    = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1'b1);
            end
         end
         ST_DONE: begin
            w_stall     = 1'b0;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_ce_nxt    = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ce    <= '0;
         r_we    <= 1'b0;
         r_addr  <= 32'h0000_0000;
         r_sel   <= 4'b0000;
         r_wdata <= 32'h0000_0000;
         r_rdata <= 32'h0000_0000;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ce    <= w_ce_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_sel   <= w_sel_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign s_ce_o      = r_ce;
   assign s_we_o      = r_we;
   assign s_addr_o    = r_addr;
   assign s_sel_o     = r_sel;
   assign s_data_o    = r_wdata;
   assign cpu_data_o  = r_rdata;
   assign cpu_err_o   = r_err;
   // Stall is combinational from the request in IDLE, forced low while reset is held
   assign cpu_stall_o = w_stall & ~rst;

endmodule

// File: tb/tb_sopc_bus_fabric.sv
// Self-checking bench for sopc_bus_fabric: directed test-plan scenarios plus randomized
// transactions checked against a transaction-level latency/data model.
module tb_sopc_bus_fabric;

   localparam int NS = 4;
   localparam int TO = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic            cpu_ce_i, cpu_we_i;
   logic [31:0]     cpu_addr_i, cpu_data_i;
   logic [3:0]      cpu_sel_i;
   logic [31:0]     cpu_data_o;
   logic            cpu_stall_o, cpu_err_o;
   logic [NS-1:0]   s_ce_o;
   logic            s_we_o;
   logic [31:0]     s_addr_o, s_data_o;
   logic [3:0]      s_sel_o;
   logic [32*NS-1:0] s_data_i;
   logic [NS-1:0]   s_ack_i;

   int              n_cmp = 0;
   int              n_bad = 0;
   logic [31:0]     model_data;

   always #5 clk = ~clk;

   sopc_bus_fabric #(.NUM_SLAVES(NS), .DEC_HI(31), .DEC_LO(28), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .cpu_stall_o(cpu_stall_o), .cpu_err_o(cpu_err_o),
      .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
      .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
   );

   // One transaction; waits<0 means the slave never acks. Entered and left just after a negedge in IDLE.
   task automatic run_txn(input string name, input logic [31:0] addr, input logic we,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input logic [31:0] rdword, input int waits, input bit spur);
      int          idx, exp_stall, exp_acc, c, acc;
      bit          mapped, acked, done, err_early, ce_bad, bc_bad, stall0_bad;
      logic        exp_err;
      logic [31:0] exp_data;
      logic [NS-1:0] exp_ce, ack;
      idx    = int'(addr[31:28]);
      mapped = (idx < NS);
      exp_ce = '0;
      if (mapped) exp_ce[idx] = 1'b1;
      acked  = mapped && (waits >= 0) && (waits + 1 <= TO);
      if (!mapped) begin
         exp_stall = 1; exp_acc = 0; exp_err = 1'b1; exp_data = model_data;
      end else if (acked) begin
         exp_stall = waits + 2; exp_acc = waits + 1; exp_err = 1'b0;
         exp_data  = we ? model_data : rdword;
      end else begin
         exp_stall = TO + 1; exp_acc = TO; exp_err = 1'b1; exp_data = model_data;
      end
      for (int k = 0; k < NS; k++) s_data_i[32*k +: 32] = $urandom;
      if (mapped) s_data_i[32*idx +: 32] = rdword;
      cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
      s_ack_i  = '0;
      #1;
      c = 0; acc = 0; done = 1'b0;
      err_early = 1'b0; ce_bad = 1'b0; bc_bad = 1'b0; stall0_bad = 1'b0;
      while (!done && c < 200) begin
         if (c > 0 && cpu_stall_o === 1'b0) begin
            done = 1'b1;
         end else begin
            if (c == 0 && cpu_stall_o !== 1'b1) stall0_bad = 1'b1;
            if (cpu_err_o !== 1'b0) err_early = 1'b1;
            if (s_ce_o !== '0) begin
               acc++;
               if (s_ce_o !== exp_ce) ce_bad = 1'b1;
               if (s_we_o !== we || s_addr_o !== addr || s_sel_o !== sel || s_data_o !== wdata)
                  bc_bad = 1'b1;
            end
            ack = spur ? NS'($urandom) : '0;
            if (c > 0) begin
               ack = ack & ~exp_ce;
               if (acked && s_ce_o !== '0 && acc == waits + 1) ack = ack | exp_ce;
            end
            s_ack_i = ack;
            @(negedge clk); #1;
            c++;
         end
      end
      s_ack_i = '0; cpu_ce_i = 1'b0;
      n_cmp++;
      if (!done) begin
         n_bad++; $display("FAIL %s completion: no DONE within %0d cycles, want %0d", name, c, exp_stall);
      end
      n_cmp++;
      if (c !== exp_stall) begin
         n_bad++; $display("FAIL %s stall_cycles: got %0d want %0d", name, c, exp_stall);
      end
      n_cmp++;
      if (acc !== exp_acc) begin
         n_bad++; $display("FAIL %s s_ce_cycles: got %0d want %0d", name, acc, exp_acc);
      end
      n_cmp++;
      if (cpu_err_o !== exp_err) begin
         n_bad++; $display("FAIL %s cpu_err_o: got %b want %b", name, cpu_err_o, exp_err);
      end
      n_cmp++;
      if (cpu_data_o !== exp_data) begin
         n_bad++; $display("FAIL %s cpu_data_o: got %h want %h", name, cpu_data_o, exp_data);
      end
      n_cmp++;
      if (s_ce_o !== '0) begin
         n_bad++; $display("FAIL %s s_ce_done: got %b want 0", name, s_ce_o);
      end
      n_cmp++;
      if ({stall0_bad, err_early, ce_bad, bc_bad} !== 4'b0000) begin
         n_bad++;
         $display("FAIL %s in_flight flags(stall0,err_early,ce,bcast): got %b want 0000",
                  name, {stall0_bad, err_early, ce_bad, bc_bad});
      end
      model_data = exp_data;
      @(negedge clk); #1;
      n_cmp++;
      if (cpu_err_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
         n_bad++; $display("FAIL %s after_done err/stall: got %b%b want 00", name, cpu_err_o, cpu_stall_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h1000_0000;
      cpu_sel_i = 4'hF; cpu_data_i = 32'hA5A5_A5A5; s_data_i = '0; s_ack_i = '1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({s_ce_o, s_we_o, s_sel_o} !== '0 || s_addr_o !== 32'h0 || s_data_o !== 32'h0) begin
         n_bad++; $display("FAIL reset_slave_side: got ce=%b we=%b addr=%h sel=%b data=%h want 0",
                           s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o);
      end
      n_cmp++;
      if (cpu_data_o !== 32'h0 || cpu_err_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_cpu_side: got data=%h err=%b stall=%b want 0",
                           cpu_data_o, cpu_err_o, cpu_stall_o);
      end
      cpu_ce_i = 1'b0; s_ack_i = '0;
      @(negedge clk); rst = 1'b0; #1;
      model_data = 32'h0;
   endtask

   task automatic test_directed();
      run_txn("read_s1", 32'h1000_0010, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      run_txn("write_s0_ws3", 32'h0000_0004, 1'b1, 4'b0011, 32'h1234_5678, 32'h0BAD_0BAD, 3, 1'b0);
      run_txn("unmapped", 32'h5000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 0, 1'b0);
   endtask

   task automatic test_timeout();
      run_txn("timeout_s2", 32'h2000_0100, 1'b0, 4'hF, 32'h0, 32'hFACE_0001, -1, 1'b0);
      run_txn("after_timeout", 32'h3000_0008, 1'b0, 4'hF, 32'h0, 32'h0123_4567, 2, 1'b0);
      run_txn("ack_on_timeout", 32'h1000_0020, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0);
      run_txn("ack_past_timeout", 32'h0000_0030, 1'b0, 4'hF, 32'h0, 32'h7777_7777, TO, 1'b0);
   endtask

   task automatic test_spurious();
      s_ack_i = '1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (s_ce_o !== '0 || cpu_stall_o !== 1'b0 || cpu_err_o !== 1'b0) begin
            n_bad++; $display("FAIL idle_ack: got ce=%b stall=%b err=%b want 0", s_ce_o, cpu_stall_o, cpu_err_o);
         end
      end
      s_ack_i = '0;
      run_txn("spurious_s1", 32'h1000_0040, 1'b0, 4'hF, 32'h0, 32'h5A5A_1234, 4, 1'b1);
   endtask

   task automatic test_mid_reset();
      int errs;
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h2000_0044;
      cpu_sel_i = 4'hF; cpu_data_i = 32'h8765_4321; s_ack_i = '0;
      repeat (5) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (s_ce_o !== '0 || s_we_o !== 1'b0 || s_addr_o !== 32'h0 || s_sel_o !== 4'h0 || s_data_o !== 32'h0) begin
         n_bad++; $display("FAIL midreset_slave_side: got ce=%b we=%b addr=%h sel=%b data=%h want 0",
                           s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o);
      end
      n_cmp++;
      if (cpu_data_o !== 32'h0 || cpu_err_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
         n_bad++; $display("FAIL midreset_cpu_side: got data=%h err=%b stall=%b want 0",
                           cpu_data_o, cpu_err_o, cpu_stall_o);
      end
      @(negedge clk); rst = 1'b0; cpu_ce_i = 1'b0; #1;
      model_data = 32'h0;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         if (cpu_err_o !== 1'b0 || s_ce_o !== '0 || cpu_stall_o !== 1'b0) errs++;
         @(negedge clk); #1;
      end
      n_cmp++;
      if (errs !== 0) begin
         n_bad++; $display("FAIL midreset_release: got %0d cycles with err/ce/stall activity want 0", errs);
      end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int          w;
      for (int i = 0; i < 30; i++) begin
         addr = {4'($urandom_range(0, 6)), 28'($urandom)};
         w    = $urandom_range(0, 18);
         if (w == 18) w = -1;
         run_txn("random", addr, 1'($urandom), 4'($urandom), $urandom, $urandom, w, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_spurious();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
